// File: rtl/alu_seq.sv
// alu_seq: multicycle operand sequencer feeding an external ALU stage.
// Optional repeat mode is enabled by defining ALU_SEQ_REPEAT_EN.
module alu_seq #(
   parameter int REGS = 8,
   parameter int W = 16,
   localparam int AW = $clog2(REGS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [2:0]    opc_in,
   input  logic          inc_in,
`ifdef ALU_SEQ_REPEAT_EN
   input  logic [3:0]    rep_in,
`endif
   input  logic [AW-1:0] sa,
   input  logic [AW-1:0] sb,
   input  logic [AW-1:0] sd,
   input  logic          ld,
   input  logic [AW-1:0] ld_addr,
   input  logic [W-1:0]  ld_data,
   input  logic [AW-1:0] rd_addr,
   output logic [W-1:0]  rd_data,
   output logic [W-1:0]  aluA,
   output logic [W-1:0]  aluB,
   output logic [2:0]    aluOpc,
   output logic          aluInc,
   input  logic [W-1:0]  aluW,
   input  logic          aluZer,
   input  logic          aluNeg,
   output logic          busy,
   output logic          done,
   output logic          zf,
   output logic          nf
);

   typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;

   state_t state, next;

   logic [W-1:0]  regs [REGS];
   logic [2:0]    opc_q;
   logic          inc_q;
   logic [AW-1:0] sa_q, sb_q, sd_q;
   logic [W-1:0]  res_q;
   logic          zer_q, neg_q;
   logic          last;
   logic          accept, load, rd_en, ex_en, wb_en, fin;

`ifdef ALU_SEQ_REPEAT_EN
   logic [3:0] rep_q;
   assign last = (rep_q == 4'd0);
`else
   assign last = 1'b1;
`endif

   assign rd_data = regs[rd_addr];

   // state register
   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= next;
   end

   // next-state logic; a non-final WRITE loops back to re-read operands
   always_comb begin
      next = state;
      unique case (state)
         IDLE:  if (start) next = READ;
         READ:  next = EXEC;
         EXEC:  next = WRITE;
         WRITE: next = last ? IDLE : READ;
         default: next = IDLE;
      endcase
   end

   // per-state control strobes; start and ld only count while idle
   always_comb begin
      accept = (state == IDLE) && start;
      load   = (state == IDLE) && ld;
      rd_en  = (state == READ);
      ex_en  = (state == EXEC);
      wb_en  = (state == WRITE);
      fin    = wb_en && last;
   end

   // register file: preload while idle, result writeback in WRITE
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < REGS; i++) regs[i] <= '0;
      end else begin
         if (load)  regs[ld_addr] <= ld_data;
         if (wb_en) regs[sd_q]    <= res_q;
      end
   end

   // command latch, operand staging, result capture and status flags
   always_ff @(posedge clk) begin
      if (!rst) begin
         opc_q  <= '0;
         inc_q  <= 1'b0;
         sa_q   <= '0;
         sb_q   <= '0;
         sd_q   <= '0;
         aluA   <= '0;
         aluB   <= '0;
         aluOpc <= 3'b111;
         aluInc <= 1'b0;
         res_q  <= '0;
         zer_q  <= 1'b0;
         neg_q  <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
         zf     <= 1'b0;
         nf     <= 1'b0;
`ifdef ALU_SEQ_REPEAT_EN
         rep_q  <= '0;
`endif
      end else begin
         done <= fin;
         if (accept) begin
            opc_q <= opc_in;
            inc_q <= inc_in;
            sa_q  <= sa;
            sb_q  <= sb;
            sd_q  <= sd;
            busy  <= 1'b1;
`ifdef ALU_SEQ_REPEAT_EN
            rep_q <= rep_in;
`endif
         end
         if (rd_en) begin
            aluA   <= regs[sa_q];
            aluB   <= regs[sb_q];
            aluOpc <= opc_q;
            aluInc <= inc_q;
         end
         if (ex_en) begin
            res_q <= aluW;
            zer_q <= aluZer;
            neg_q <= aluNeg;
         end
         if (wb_en) begin
            zf <= zer_q;
            nf <= neg_q;
`ifdef ALU_SEQ_REPEAT_EN
            if (!last) rep_q <= rep_q - 4'd1;
`endif
         end
         if (fin) busy <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed scoreboard bench for alu_seq with a behavioural ALU.
// Repeat-mode steps are built only when ALU_SEQ_REPEAT_EN is defined.
module tb_alu_seq;

   logic        clk, rst, start, inc_in, ld;
   logic [2:0]  opc_in, sa, sb, sd, ld_addr, rd_addr;
   logic [15:0] ld_data, rd_data, aluA, aluB, aluW;
   logic [2:0]  aluOpc;
   logic        aluInc, aluZer, aluNeg, busy, done, zf, nf;
`ifdef ALU_SEQ_REPEAT_EN
   logic [3:0]  rep_in;
`endif

   typedef struct {
      logic [2:0]  sd;
      logic [15:0] val;
      logic        z;
      logic        n;
      int          lat;
   } exp_t;

   exp_t        sbq[$];
   logic [15:0] m [8];
   int          checks = 0;
   int          failures = 0;

   alu_seq dut (
      .clk(clk), .rst(rst), .start(start), .opc_in(opc_in),
      .inc_in(inc_in),
`ifdef ALU_SEQ_REPEAT_EN
      .rep_in(rep_in),
`endif
      .sa(sa), .sb(sb), .sd(sd), .ld(ld), .ld_addr(ld_addr),
      .ld_data(ld_data), .rd_addr(rd_addr), .rd_data(rd_data),
      .aluA(aluA), .aluB(aluB), .aluOpc(aluOpc), .aluInc(aluInc),
      .aluW(aluW), .aluZer(aluZer), .aluNeg(aluNeg),
      .busy(busy), .done(done), .zf(zf), .nf(nf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] alu_f(input logic [2:0] op,
      input logic [15:0] a, input logic [15:0] b, input logic c);
      case (op)
         3'b000:  return -a;
         3'b001:  return a + 16'd1;
         3'b010:  return a + b + {15'd0, c};
         3'b110:  return {a[7:0], b[7:0]};
         default: return 16'd0;
      endcase
   endfunction

   // behavioural stand-in for the downstream ALU stage
   always_comb begin
      aluW   = alu_f(aluOpc, aluA, aluB, aluInc);
      aluZer = (aluW == 16'd0);
      aluNeg = aluW[15];
   end

   initial begin
      #2000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] obs,
                        input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic read_chk(input string tag, input logic [2:0] a,
                           input logic [15:0] exp);
      rd_addr = a;
      #1;
      check(tag, rd_data, exp);
   endtask

   task automatic do_ld(input logic [2:0] a, input logic [15:0] d);
      ld = 1'b1;
      ld_addr = a;
      ld_data = d;
      step();
      ld = 1'b0;
      m[a] = d;
   endtask

   task automatic issue(input logic [2:0] op, input logic c,
      input logic [2:0] a, input logic [2:0] b, input logic [2:0] d,
      input logic [3:0] rep, input bit track);
      logic [15:0] v;
      v = 16'd0;
      if (track) begin
         for (int i = 0; i <= int'(rep); i++) begin
            v = alu_f(op, m[a], m[b], c);
            m[d] = v;
         end
         sbq.push_back('{sd: d, val: v, z: (v == 16'd0), n: v[15],
                         lat: 3 * (int'(rep) + 1)});
      end
      opc_in = op;
      inc_in = c;
      sa = a;
      sb = b;
      sd = d;
`ifdef ALU_SEQ_REPEAT_EN
      rep_in = rep;
`endif
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   // lat0 = edges already elapsed since the accepting edge
   task automatic wait_done(input string tag, input int lat0);
      exp_t e;
      int   lat;
      lat = lat0;
      while (!done && lat < 40) begin
         check({tag, "_busy"}, busy, 1'b1);
         step();
         lat++;
      end
      if (sbq.size() == 0) begin
         check({tag, "_sb_empty"}, 16'd1, 16'd0);
         return;
      end
      e = sbq.pop_front();
      check({tag, "_done_seen"}, done, 1'b1);
      check({tag, "_latency"}, lat[15:0], e.lat[15:0]);
      check({tag, "_busy_end"}, busy, 1'b0);
      check({tag, "_zf"}, zf, e.z);
      check({tag, "_nf"}, nf, e.n);
      read_chk({tag, "_rd"}, e.sd, e.val);
   endtask

   initial begin
      rst = 1'b0;
      start = 1'b0;
      ld = 1'b0;
      opc_in = 3'd0;
      inc_in = 1'b0;
      sa = 3'd0;
      sb = 3'd0;
      sd = 3'd0;
      ld_addr = 3'd0;
      ld_data = 16'd0;
      rd_addr = 3'd0;
`ifdef ALU_SEQ_REPEAT_EN
      rep_in = 4'd0;
`endif
      for (int i = 0; i < 8; i++) m[i] = 16'd0;

      // reset state
      step();
      step();
      rst = 1'b1;
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_zf", zf, 1'b0);
      check("rst_nf", nf, 1'b0);
      check("rst_opc", aluOpc, 3'b111);
      check("rst_aluA", aluA, 16'd0);
      for (int i = 0; i < 8; i++) read_chk("rst_reg", 3'(i), 16'd0);

      // add with carry: 5 + 7 + 1
      do_ld(3'd1, 16'd5);
      do_ld(3'd2, 16'd7);
      issue(3'b010, 1'b1, 3'd1, 3'd2, 3'd3, 4'd0, 1'b1);
      wait_done("add", 0);
      read_chk("add_r3", 3'd3, 16'd13);
      step();
      check("add_done_once", done, 1'b0);

      // negate, then opcode 111
      do_ld(3'd1, 16'd1);
      issue(3'b000, 1'b0, 3'd1, 3'd0, 3'd4, 4'd0, 1'b1);
      wait_done("neg", 0);
      read_chk("neg_r4", 3'd4, 16'hFFFF);
      check("neg_nf", nf, 1'b1);
      issue(3'b111, 1'b0, 3'd1, 3'd2, 3'd5, 4'd0, 1'b1);
      wait_done("zero", 0);
      read_chk("zero_r5", 3'd5, 16'h0000);
      check("zero_zf", zf, 1'b1);

      // concatenate with sd == sa; pulses while busy must be ignored
      do_ld(3'd1, 16'h12AB);
      do_ld(3'd2, 16'h34CD);
      issue(3'b110, 1'b0, 3'd1, 3'd2, 3'd1, 4'd0, 1'b1);
      start = 1'b1;
      opc_in = 3'b000;
      sd = 3'd0;
      ld = 1'b1;
      ld_addr = 3'd2;
      ld_data = 16'hDEAD;
      step();
      start = 1'b0;
      ld = 1'b0;
      wait_done("cat", 1);
      read_chk("cat_r1", 3'd1, 16'hABCD);
      // back-to-back start in the done cycle
      issue(3'b010, 1'b0, 3'd1, 3'd2, 3'd6, 4'd0, 1'b1);
      check("b2b_busy", busy, 1'b1);
      wait_done("b2b", 0);
      read_chk("b2b_r6", 3'd6, 16'hE09A);
      for (int i = 0; i < 8; i++) read_chk("regs_hold", 3'(i), m[i]);
      for (int i = 0; i < 4; i++) begin
         step();
         check("idle_no_done", done, 1'b0);
      end

      // reset asserted during EXEC aborts the command
      issue(3'b010, 1'b1, 3'd3, 3'd3, 3'd7, 4'd0, 1'b0);
      step();
      rst = 1'b0;
      step();
      rst = 1'b1;
      for (int i = 0; i < 8; i++) m[i] = 16'd0;
      for (int i = 0; i < 5; i++) begin
         check("abort_done", done, 1'b0);
         check("abort_busy", busy, 1'b0);
         step();
      end
      read_chk("abort_r7", 3'd7, 16'd0);
      check("abort_opc", aluOpc, 3'b111);
      do_ld(3'd2, 16'h8001);
      issue(3'b010, 1'b0, 3'd2, 3'd0, 3'd3, 4'd0, 1'b1);
      wait_done("post_rst", 0);

`ifdef ALU_SEQ_REPEAT_EN
      // repeat: R1 incremented five times in place
      do_ld(3'd1, 16'd3);
      issue(3'b001, 1'b0, 3'd1, 3'd1, 3'd1, 4'd4, 1'b1);
      wait_done("rep", 0);
      read_chk("rep_r1", 3'd1, 16'd8);
      step();
      check("rep_done_once", done, 1'b0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Multicycle operand sequencer placed directly upstream of the 16-bit ALU_2 stage (inA/inB/opc/inc in, w/zer/neg out). ALU_2 is instantiated outside this block.
- Holds an 8 x 16-bit register file. Accepts one command at a time (opcode, two source registers, one destination register, carry-in).
- Drives registered operands into the ALU, captures its result and flags, and writes the result back to the register file.
- Separate load and read ports let the surrounding logic preload registers and observe them.

Parameters:
- REGS, 8, register-file depth. The index width is derived as clog2(REGS); index ports below are 3 bits at the default.
- W, 16, datapath width. Must match the ALU width.

Ports:
- clk input 1: single clock, rising edge.
- rst input 1: reset, synchronous, active-low (asserted when 0, sampled on the clk rising edge).
- start input 1: command request. Accepted only when busy=0.
- opc_in input 3: ALU opcode for the command.
- inc_in input 1: carry-in for the command (used by the ALU only when opcode=010).
- sa input 3: source register index for inA.
- sb input 3: source register index for inB.
- sd input 3: destination register index.
- ld input 1: register preload strobe. Honoured only when busy=0.
- ld_addr input 3: preload index.
- ld_data input 16: preload value.
- rd_addr input 3: observation index.
- rd_data output 16: combinational read of regs[rd_addr].
- aluA output 16: registered operand to ALU inA.
- aluB output 16: registered operand to ALU inB.
- aluOpc output 3: registered opcode to ALU opc.
- aluInc output 1: registered carry-in to ALU inc.
- aluW input 16: ALU result w.
- aluZer input 1: ALU zer flag.
- aluNeg input 1: ALU neg flag.
- busy output 1: high from command acceptance until writeback completes.
- done output 1: one-cycle pulse marking completion.
- zf output 1: zero flag of the last writeback.
- nf output 1: negative flag of the last writeback.

Behaviour:
- Reset (rst=0 at an edge):
  - State goes to IDLE; all registers are cleared to 0.
  - aluA=0, aluB=0, aluOpc=3'b111, aluInc=0.
  - busy=0, done=0, zf=0, nf=0.
  - Any in-flight command is dropped and no writeback occurs.
- FSM states: IDLE, READ, EXEC, WRITE.
- IDLE:
  - If start=1 at edge E0, latch opc_in, inc_in, sa, sb and sd; go to READ; busy=1.
  - If ld=1, regs[ld_addr] <= ld_data.
  - ld and start in the same cycle are both honoured. The operand read in READ sees the loaded value.
- READ, at edge E1:
  - aluA <= regs[sa], aluB <= regs[sb], aluOpc <= latched opcode, aluInc <= latched carry-in.
  - Go to EXEC.
- EXEC, at edge E2: result register <= aluW, flag registers <= {aluZer, aluNeg}; go to WRITE.
- WRITE, at edge E3:
  - regs[sd] <= result; zf and nf updated.
  - done <= 1 for exactly one cycle; busy <= 0; go to IDLE.
- Latency and timing:
  - Start-to-done latency is 3 cycles. Results are visible on rd_data and zf/nf in the same cycle done is high.
  - The next start is accepted in the done cycle at the earliest, giving a throughput of one command per 4 cycles.
- While busy=1, start and ld are ignored (no queueing).
- Operand read after write: sd may equal sa or sb; sequential ordering guarantees the old value is read.
- Register 0 is an ordinary register (not hardwired).
- Opcode 111 yields result 0 (the ALU default), so zf=1 and nf=0 after writeback.
- aluA, aluB, aluOpc and aluInc hold their values between commands.

Optional Feature:
- Macro ALU_SEQ_REPEAT_EN.
- Enabled:
  - Adds input rep_in (4 bits), latched with the command.
  - WRITE with a nonzero remaining count decrements the count and returns to READ instead of IDLE. Operands are re-read, so sd==sa accumulates.
  - Total executions = rep_in+1. done pulses once, after the final WRITE, at 3*(rep_in+1) cycles after E0.
  - busy stays high throughout the repeats.
  - Reset mid-repeat aborts all remaining iterations.
- Disabled: the rep_in port is absent and every command executes exactly once.

Test Plan:
- Reset values: hold rst=0 for 2 cycles, then release. Required: all regs=0, busy=0, done=0, zf=0, nf=0, aluOpc=111.
- Add with carry: preload R1=5, R2=7; start opc=010, inc=1, sa=1, sb=2, sd=3. Required: done exactly 3 cycles after the start edge, R3=13, zf=0, nf=0.
- Negate: R1=1; opc=000, sa=1, sd=4. Required: R4=0xFFFF, nf=1, zf=0. Then opc=111, sd=5: R5=0, zf=1, nf=0.
- Concatenate, back-to-back, busy blocking:
  - R1=0x12AB, R2=0x34CD; opc=110, sa=1, sb=2, sd=1. Required: R1=0xABCD; operand read before write.
  - Assert start again in the done cycle. Required: accepted.
  - start/ld pulses while busy=1. Required: ignored, registers unchanged.
- Reset mid-operation: drive rst=0 in the EXEC cycle. Required: no writeback to sd, done never pulses, state IDLE.
- With ALU_SEQ_REPEAT_EN: R1=3; opc=001, sa=1, sd=1, rep_in=4. Required: R1=8, a single done pulse 15 cycles after the start edge, busy high throughout.
